lsu_mem_master: RTL

- Load/store initiator that sits between the core's execute stage and the word-organised data memory, and drives the memory's clk/address/data/iWrite/out interface.
- Accepts one byte, halfword or word load/store request at a time and checks alignment.
- Implements sub-word stores as read-modify-write, because the memory writes whole words only.
- Performs little-endian lane extraction and sign or zero extension on loads, then returns a single response per request.

---
 rtl/lsu_mem_master.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and a word-organised data memory.
// Handles alignment checks, read-modify-write for sub-word stores and
// little-endian lane extraction with sign/zero extension on loads.
module lsu_mem_master #(
  parameter int XLEN       = 32,
  parameter int ADDRESSLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDRESSLEN-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic [ADDRESSLEN-1:0] mem_address,
  output logic [XLEN-1:0]       mem_data,
  output logic                  mem_iWrite,
  input  logic [XLEN-1:0]       mem_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [1:0]            r_addr_lo;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [15:0]           r_wdata;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [XLEN-1:0]       r_resp_rdata;
  logic [ADDRESSLEN-1:0] r_mem_address;
  logic [XLEN-1:0]       r_mem_data;
  logic                  r_mem_iWrite;

  logic [1:0]            w_addr_lo;
  logic [1:0]            w_size;
  logic                  w_unsigned;
  logic [15:0]           w_wdata;
  logic                  w_resp_valid;
  logic                  w_resp_err;
  logic [XLEN-1:0]       w_resp_rdata;
  logic [ADDRESSLEN-1:0] w_mem_address;
  logic [XLEN-1:0]       w_mem_data;
  logic                  w_mem_iWrite;

  logic                  w_misaligned;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_load_data;
  logic [XLEN-1:0]       w_merged;

  assign req_ready   = (r_state == IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_iWrite  = r_mem_iWrite;

  // Illegal size or an address not aligned to the access width.
  assign w_misaligned = (req_size == 2'b11) ||
                        ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Pick the addressed byte/halfword lane of the memory word and extend it.
  always_comb begin
    w_byte      = mem_out[7:0];
    w_half      = mem_out[15:0];
    w_load_data = mem_out;
    case (r_addr_lo)
      2'd1:    w_byte = mem_out[15:8];
      2'd2:    w_byte = mem_out[23:16];
      2'd3:    w_byte = mem_out[31:24];
      default: w_byte = mem_out[7:0];
    endcase
    if (r_addr_lo[1]) w_half = mem_out[31:16];
    case (r_size)
      2'b00:   w_load_data = {{(XLEN-8){w_byte[7] & ~r_unsigned}}, w_byte};
      2'b01:   w_load_data = {{(XLEN-16){w_half[15] & ~r_unsigned}}, w_half};
      default: w_load_data = mem_out;
    endcase
  end

  // Merge the store data into the addressed lane, leaving other lanes intact.
  always_comb begin
    w_merged = mem_out;
    if (r_size == 2'b00) begin
      case (r_addr_lo)
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        2'd3:    w_merged[31:24] = r_wdata[7:0];
        default: w_merged[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_addr_lo[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  // Next-state and next-output decode; response and write strobes default low.
  always_comb begin
    w_next_state  = r_state;
    w_addr_lo     = r_addr_lo;
    w_size        = r_size;
    w_unsigned    = r_unsigned;
    w_wdata       = r_wdata;
    w_resp_valid  = 1'b0;
    w_resp_err    = 1'b0;
    w_resp_rdata  = '0;
    w_mem_address = r_mem_address;
    w_mem_data    = r_mem_data;
    w_mem_iWrite  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_addr_lo     = req_addr[1:0];
          w_size        = req_size;
          w_unsigned    = req_unsigned;
          w_wdata       = req_wdata[15:0];
          w_mem_address = {req_addr[ADDRESSLEN-1:2], 2'b00};
          if (w_misaligned) begin
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
            w_next_state = RESP;
          end else if (!req_write) begin
            w_next_state = READ;
          end else if (req_size == 2'b10) begin
            w_mem_data   = req_wdata;
            w_mem_iWrite = 1'b1;
            w_next_state = WRITE;
          end else begin
            w_next_state = RMW_RD;
          end
        end
      end
      READ: begin
        w_resp_rdata = w_load_data;
        w_resp_valid = 1'b1;
        w_next_state = RESP;
      end
      RMW_RD: begin
        w_mem_data   = w_merged;
        w_mem_iWrite = 1'b1;
        w_next_state = WRITE;
      end
      WRITE: begin
        w_resp_valid = 1'b1;
        w_next_state = RESP;
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Request latches and registered outputs; reset kills any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_lo     <= '0;
      r_size        <= '0;
      r_unsigned    <= 1'b0;
      r_wdata       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_iWrite  <= 1'b0;
    end else begin
      r_addr_lo     <= w_addr_lo;
      r_size        <= w_size;
      r_unsigned    <= w_unsigned;
      r_wdata       <= w_wdata;
      r_resp_valid  <= w_resp_valid;
      r_resp_err    <= w_resp_err;
      r_resp_rdata  <= w_resp_rdata;
      r_mem_address <= w_mem_address;
      r_mem_data    <= w_mem_data;
      r_mem_iWrite  <= w_mem_iWrite;
    end
  end

endmodule
